// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: drops off-frame pixels, linearises kept ones into framebuffer
// addresses, queues them and drains one write per unstalled cycle, then forwards done.
module pixel_write_buffer #(
    parameter int PIXEL_WIDTH  = 1280,
    parameter int PIXEL_HEIGHT = 720,
    parameter int COLOR_WIDTH  = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                        clk_in,
    input  logic                                        rst_n_in,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]              hcount_in,
    input  logic [$clog2(PIXEL_HEIGHT)-1:0]             vcount_in,
    input  logic [COLOR_WIDTH-1:0]                      color_in,
    input  logic                                        valid_in,
    input  logic                                        done_in,
    output logic                                        ready_out,
    input  logic                                        stall_in,
    output logic [$clog2(PIXEL_WIDTH*PIXEL_HEIGHT)-1:0] addr_out,
    output logic [COLOR_WIDTH-1:0]                      data_out,
    output logic                                        we_out,
    output logic                                        done_out,
    output logic [$clog2(FIFO_DEPTH):0]                 count_out,
    output logic                                        overflow_out
);

    localparam int HW = $clog2(PIXEL_WIDTH);
    localparam int VW = $clog2(PIXEL_HEIGHT);
    localparam int AW = $clog2(PIXEL_WIDTH*PIXEL_HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]          addr;
        logic [COLOR_WIDTH-1:0] data;
    } pix_t;

    pix_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pending;

    logic          in_range, push, pop, drop, fire;
    logic [AW-1:0] lin_addr;

    // Extra top bit keeps the bound comparable even when the frame size is a power of 2.
    assign in_range = ({1'b0, hcount_in} < (HW+1)'(PIXEL_WIDTH)) &&
                      ({1'b0, vcount_in} < (VW+1)'(PIXEL_HEIGHT));
    assign ready_out = count < CW'(FIFO_DEPTH);
    assign push      = valid_in && ready_out && in_range;
    assign drop      = valid_in && !ready_out && in_range;
    assign pop       = (count != '0) && !stall_in;
    assign fire      = pending && (count == '0) && !push;
    assign lin_addr  = AW'(vcount_in) * AW'(PIXEL_WIDTH) + AW'(hcount_in);
    assign count_out = count;

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= '{addr: lin_addr, data: color_in};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending      <= 1'b0;
            we_out       <= 1'b0;
            done_out     <= 1'b0;
            overflow_out <= 1'b0;
            addr_out     <= '0;
            data_out     <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                addr_out <= mem[rd_ptr].addr;
                data_out <= mem[rd_ptr].data;
            end
            we_out <= pop;
            if (drop) overflow_out <= 1'b1;
            // A done arriving while one is already pending folds into the same pulse.
            done_out <= fire;
            if (fire)         pending <= 1'b0;
            else if (done_in) pending <= 1'b1;
        end
    end

endmodule
